// File: rtl/video_ddr_pkg.sv
// video_ddr_pkg: pixel/word geometry, FSM encodings and word packing shared by the
// video-to-DDR and DDR-to-video controllers.
package video_ddr_pkg;
    localparam int PIX_PER_WORD = 4;
    localparam int PIX_SLOT_W   = 32;
    localparam int PIX_W        = 24;
    localparam int PAD_W        = PIX_SLOT_W - PIX_W;
    localparam int WORD_W       = PIX_PER_WORD * PIX_SLOT_W;

    typedef enum logic {WAIT_VS = 1'b0, ACTIVE = 1'b1} vid_state_e;

    typedef logic [PIX_PER_WORD-1:0][PIX_W-1:0] pix_vec_t;

    // Slot 0 lands in the most significant 32 bits; each pixel is followed by zero padding.
    function automatic logic [WORD_W-1:0] pack_word(input pix_vec_t p);
        return {p[0], {PAD_W{1'b0}}, p[1], {PAD_W{1'b0}},
                p[2], {PAD_W{1'b0}}, p[3], {PAD_W{1'b0}}};
    endfunction
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: gathers 24-bit pixels into 4-slot 128-bit words, flushes partial words
// at line end and drops writes that meet a full FIFO.
module pixel_packer
    import video_ddr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              pix_vld_i,
    input  logic              line_end_i,
    input  logic [PIX_W-1:0]  pix_i,
    input  logic              fifo_full_i,
    output logic [WORD_W-1:0] data_o,
    output logic              wr_en_o,
    output logic              overflow_o
);
    logic [1:0]        cnt_q, cnt_d;
    pix_vec_t          slot_q, slot_d;
    logic [WORD_W-1:0] data_q;
    logic              wr_en_q, ovf_q, wr_due;

    always_comb begin
        slot_d = slot_q;
        if (pix_vld_i) begin
            // Starting a word wipes stale slots so a later flush reads them as zero.
            if (cnt_q == 2'd0) slot_d = '0;
            slot_d[cnt_q] = pix_i;
        end
        cnt_d  = (clear_i || line_end_i) ? 2'd0 : pix_vld_i ? cnt_q + 2'd1 : cnt_q;
        wr_due = (pix_vld_i && cnt_q == 2'd3) || (line_end_i && cnt_q != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            slot_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            wr_en_q <= wr_due && !fifo_full_i;
            ovf_q   <= ovf_q || (wr_due && fifo_full_i);
            if (wr_due) data_q <= pack_word(slot_d);
        end
    end

    assign data_o     = data_q;
    assign wr_en_o    = wr_en_q;
    assign overflow_o = ovf_q;
endmodule

// File: rtl/video_to_fifo_ctrl.sv
// video_to_fifo_ctrl: frame-sync FSM, line counter and DDR burst handshake around a
// pixel packer that writes 4-pixel words into the write FIFO.
module video_to_fifo_ctrl
    import video_ddr_pkg::*;
#(
    parameter logic [11:0] H_DISP = 12'd1920,
    parameter logic [11:0] V_DISP = 12'd1080
) (
    input  logic               video_clk,
    input  logic               video_rst_n,
    input  logic               video_vs_in,
    input  logic               video_hs_in,
    input  logic               video_de_in,
    input  logic [PIX_W-1:0]   video_data_in,
    output logic [WORD_W-1:0]  fifo_data_out,
    output logic               fifo_wr_en,
    input  logic               fifo_full,
    output logic               AXI_FULL_BURST_VALID,
    input  logic               AXI_FULL_BURST_READY,
    output logic               frame_start,
    output logic [11:0]        line_cnt,
    output logic               overflow_err,
    output logic               burst_overrun
);
    vid_state_e  state_q;
    logic        vs_q, de_q, frame_start_q, valid_q, overrun_q;
    logic [11:0] line_cnt_q;
    logic [1:0]  pending_q, pending_d;
    logic        active, vs_fall, clear, pix_vld, line_end, dec;
    logic        unused_hs;

    assign unused_hs = video_hs_in;

    if (H_DISP == 12'd0 || V_DISP == 12'd0) begin : g_bad_geom
        $error("video_to_fifo_ctrl: H_DISP and V_DISP must be non-zero");
    end

    always_comb begin
        active    = state_q == ACTIVE;
        vs_fall   = vs_q && !video_vs_in;
        clear     = active && vs_fall;
        pix_vld   = active && !vs_fall && video_de_in;
        line_end  = active && !vs_fall && de_q && !video_de_in;
        dec       = valid_q && AXI_FULL_BURST_READY;
        pending_d = (line_end == dec) ? pending_q :
                    dec ? pending_q - 2'd1 :
                    (pending_q == 2'd3) ? pending_q : pending_q + 2'd1;
    end

    always_ff @(posedge video_clk) begin
        if (!video_rst_n) begin
            state_q       <= WAIT_VS;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            line_cnt_q    <= '0;
            pending_q     <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= vs_fall ? ACTIVE : state_q;
            vs_q          <= video_vs_in;
            // Tracking only accepted pixels keeps a frame start from looking like a line end.
            de_q          <= pix_vld;
            frame_start_q <= vs_fall;
            line_cnt_q    <= vs_fall ? 12'd0 :
                             (line_end && line_cnt_q != V_DISP) ? line_cnt_q + 12'd1 : line_cnt_q;
            pending_q     <= pending_d;
            valid_q       <= pending_d != 2'd0;
            overrun_q     <= overrun_q || (line_end && !dec && pending_q == 2'd3);
        end
    end

    pixel_packer u_packer (
        .clk         (video_clk),
        .rst_n       (video_rst_n),
        .clear_i     (clear),
        .pix_vld_i   (pix_vld),
        .line_end_i  (line_end),
        .pix_i       (video_data_in),
        .fifo_full_i (fifo_full),
        .data_o      (fifo_data_out),
        .wr_en_o     (fifo_wr_en),
        .overflow_o  (overflow_err)
    );

    assign AXI_FULL_BURST_VALID = valid_q;
    assign frame_start          = frame_start_q;
    assign line_cnt             = line_cnt_q;
    assign burst_overrun        = overrun_q;
endmodule

// File: tb/tb_video_to_fifo_ctrl.sv
// tb_video_to_fifo_ctrl: directed vectors against hand-computed words, strobes and flags;
// every FIFO write is captured into a queue for later comparison.
module tb_video_to_fifo_ctrl;
    logic         clk = 1'b0, rst_n = 1'b0, vs = 1'b0, hs = 1'b0, de = 1'b0;
    logic         full = 1'b0, ready = 1'b0;
    logic [23:0]  pix = '0;
    logic [127:0] data;
    logic         wr_en, valid, fs, ovf, ovr;
    logic [11:0]  lc;
    int           checks = 0, errors = 0, fs_cnt = 0, n0 = 0;
    logic [127:0] wq[$];

    always #5 clk = ~clk;

    video_to_fifo_ctrl #(.H_DISP(12'd8), .V_DISP(12'd4)) dut (
        .video_clk            (clk),
        .video_rst_n          (rst_n),
        .video_vs_in          (vs),
        .video_hs_in          (hs),
        .video_de_in          (de),
        .video_data_in        (pix),
        .fifo_data_out        (data),
        .fifo_wr_en           (wr_en),
        .fifo_full            (full),
        .AXI_FULL_BURST_VALID (valid),
        .AXI_FULL_BURST_READY (ready),
        .frame_start          (fs),
        .line_cnt             (lc),
        .overflow_err         (ovf),
        .burst_overrun        (ovr)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (wr_en) wq.push_back(data);
        if (fs) fs_cnt++;
    endtask

    task automatic send_px(input logic [23:0] p);
        de  = 1'b1;
        pix = p;
        step();
    endtask

    task automatic end_line();
        de = 1'b0;
        hs = 1'b1;
        step();
        hs = 1'b0;
        step();
    endtask

    task automatic new_frame();
        vs = 1'b1;
        step();
        vs = 1'b0;
        step();
    endtask

    initial begin
        repeat (3) step();
        check("rst_wr_en", 128'(wr_en), 128'(0));
        check("rst_valid", 128'(valid), 128'(0));
        check("rst_fs", 128'(fs), 128'(0));
        check("rst_line_cnt", 128'(lc), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        check("rst_ovr", 128'(ovr), 128'(0));
        check("rst_data", data, 128'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) send_px(24'h111111);
        end_line();
        check("pre_vs_writes", 128'(wq.size()), 128'(0));
        check("pre_vs_fs", 128'(fs_cnt), 128'(0));
        check("pre_vs_valid", 128'(valid), 128'(0));

        new_frame();
        check("fs_pulse", 128'(fs), 128'(1));
        step();
        check("fs_one_cycle", 128'(fs), 128'(0));
        for (int i = 1; i <= 8; i++) send_px(24'(i));
        check("valid_before_end", 128'(valid), 128'(0));
        end_line();
        check("l1_writes", 128'(wq.size()), 128'(2));
        check("l1_word0", wq[0], 128'h00000100_00000200_00000300_00000400);
        check("l1_word1", wq[1], 128'h00000500_00000600_00000700_00000800);
        check("l1_valid", 128'(valid), 128'(1));
        check("l1_line_cnt", 128'(lc), 128'(1));

        new_frame();
        check("f2_line_cnt_clr", 128'(lc), 128'(0));
        for (int i = 1; i <= 6; i++) send_px(24'hA00000 + 24'(i));
        end_line();
        check("l6_writes", 128'(wq.size()), 128'(4));
        check("l6_word0", wq[2], 128'hA0000100_A0000200_A0000300_A0000400);
        check("l6_flush", wq[3], 128'hA0000500_A0000600_00000000_00000000);
        check("l6_line_cnt", 128'(lc), 128'(1));

        for (int i = 1; i <= 4; i++) send_px(24'hB00000 + 24'(i));
        end_line();
        check("pend3_no_ovr", 128'(ovr), 128'(0));
        for (int i = 1; i <= 4; i++) send_px(24'hB10000 + 24'(i));
        end_line();
        check("sat_ovr", 128'(ovr), 128'(1));
        check("sat_valid", 128'(valid), 128'(1));
        check("sat_line_cnt", 128'(lc), 128'(3));
        for (int k = 0; k < 2; k++) begin
            ready = 1'b1;
            step();
            ready = 1'b0;
            step();
        end
        check("ready2_valid", 128'(valid), 128'(1));
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        check("ready3_valid", 128'(valid), 128'(0));

        for (int i = 1; i <= 4; i++) send_px(24'hB20000 + 24'(i));
        end_line();
        check("vdisp_line_cnt", 128'(lc), 128'(4));
        for (int i = 1; i <= 4; i++) send_px(24'hB30000 + 24'(i));
        de    = 1'b0;
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        check("inc_dec_valid", 128'(valid), 128'(1));
        check("vdisp_hold", 128'(lc), 128'(4));
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        check("dec_valid", 128'(valid), 128'(0));

        n0 = wq.size();
        for (int i = 1; i <= 3; i++) send_px(24'hC00000 + 24'(i));
        full = 1'b1;
        send_px(24'hC00004);
        full = 1'b0;
        check("full_wr_en", 128'(wr_en), 128'(0));
        check("full_ovf", 128'(ovf), 128'(1));
        for (int i = 5; i <= 8; i++) send_px(24'hC00000 + 24'(i));
        end_line();
        check("full_writes", 128'(wq.size() - n0), 128'(1));
        check("full_next_word", wq[n0], 128'hC0000500_C0000600_C0000700_C0000800);

        n0 = wq.size();
        vs = 1'b1;
        step();
        send_px(24'hD00001);
        send_px(24'hD00002);
        vs = 1'b0;
        send_px(24'hD00003);
        check("vs_discard_fs", 128'(fs), 128'(1));
        check("vs_discard_line_cnt", 128'(lc), 128'(0));
        end_line();
        check("vs_discard_writes", 128'(wq.size() - n0), 128'(0));
        check("vs_pending_kept", 128'(valid), 128'(1));
        for (int i = 1; i <= 4; i++) send_px(24'hE00000 + 24'(i));
        end_line();
        check("vs_slot_restart", wq[n0], 128'hE0000100_E0000200_E0000300_E0000400);
        check("vs_next_line_cnt", 128'(lc), 128'(1));
        check("ovf_sticky", 128'(ovf), 128'(1));

        n0 = wq.size();
        send_px(24'hF00001);
        send_px(24'hF00002);
        rst_n = 1'b0;
        de    = 1'b0;
        step();
        check("midrst_wr_en", 128'(wr_en), 128'(0));
        check("midrst_ovf", 128'(ovf), 128'(0));
        check("midrst_ovr", 128'(ovr), 128'(0));
        check("midrst_valid", 128'(valid), 128'(0));
        check("midrst_data", data, 128'(0));
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) send_px(24'hF10000 + 24'(i));
        end_line();
        check("midrst_writes", 128'(wq.size() - n0), 128'(0));
        check("midrst_line_cnt", 128'(lc), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
